// File: rtl/jump_ras_control_pkg.sv
// Shared MIPS decode constants and the jump classifier used by the jump/RAS front end.
package jump_ras_control_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_JALR = 6'b001001;
  localparam logic [4:0] REG_RA     = 5'd31;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  typedef enum logic [2:0] {
    JK_NONE,
    JK_J,
    JK_JAL,
    JK_JR,
    JK_JALR
  } jump_kind_t;

  function automatic jump_kind_t decode_kind(input instr_t ins);
    jump_kind_t k;
    k = JK_NONE;
    if (ins.op == OP_J)
      k = JK_J;
    else if (ins.op == OP_JAL)
      k = JK_JAL;
    else if (ins.op == OP_SPECIAL && ins.funct == FUNCT_JR)
      k = JK_JR;
    else if (ins.op == OP_SPECIAL && ins.funct == FUNCT_JALR)
      k = JK_JALR;
    return k;
  endfunction

endpackage

// File: rtl/jump_ras_control_ras_stack.sv
// Circular return-address stack: overwrites the oldest entry when full, pop on empty is ignored.
module ras_stack #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  logic [31:0] wdata,
  output logic [31:0] top,
  output logic        empty,
  output logic        full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] ptr_dec;
  logic [CW-1:0] count;
  logic          do_pop;

  assign ptr_inc = ptr + 1'b1;
  assign ptr_dec = ptr - 1'b1;
  assign top     = mem[ptr];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;

  // ptr always addresses the current top; a push advances first, then writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push && do_pop) begin
      mem[ptr] <= wdata;
    end else if (push) begin
      mem[ptr_inc] <= wdata;
      ptr          <= ptr_inc;
      if (!full) count <= count + 1'b1;
    end else if (do_pop) begin
      ptr   <= ptr_dec;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/jump_ras_control.sv
// Decode-stage jump resolution with return-address-stack prediction for jr/jalr $31.
module jump_ras_control
  import jump_ras_control_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int USE_RAS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrD,
  input  logic [31:0] PcPlus4D,
  input  logic [31:0] rd1D,
  input  logic        rd1_readyD,
  input  logic        validD,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        ras_clear,
  output logic        jump1D,
  output logic [31:0] pc_jump1D,
  output logic        ras_predD,
  output logic        jr_stallD
);

  localparam bit RAS_ON = (USE_RAS != 0);

  jump_kind_t  kind;
  logic [4:0]  rs;
  logic [4:0]  rd;
  logic        is_reg;
  logic        is_call;
  logic        ras_hit;
  logic        upd;
  logic        push;
  logic        pop;
  logic [31:0] ras_top;
  logic        ras_empty;

  assign kind    = decode_kind(instrD);
  assign rs      = instrD[25:21];
  assign rd      = instrD[15:11];
  assign is_reg  = (kind == JK_JR) || (kind == JK_JALR);
  assign is_call = (kind == JK_JAL) || (kind == JK_JALR && rd == REG_RA);

  // Stack is treated as empty while reset is asserted.
  assign ras_hit = RAS_ON && is_reg && (rs == REG_RA) && !ras_empty && !rst;

  always_comb begin
    jump1D    = validD && (kind != JK_NONE);
    pc_jump1D = {PcPlus4D[31:28], instrD[25:0], 2'b00};
    ras_predD = 1'b0;
    jr_stallD = 1'b0;
    if (is_reg) begin
      pc_jump1D = rd1D;
      if (validD && !rd1_readyD) begin
        if (ras_hit) begin
          pc_jump1D = ras_top;
          ras_predD = 1'b1;
        end else begin
          jr_stallD = 1'b1;
        end
      end
    end
  end

  assign upd  = validD && !stallD && !flushD && !jr_stallD && !rst && !ras_clear;
  assign push = RAS_ON && upd && is_call;
  assign pop  = RAS_ON && upd && is_reg && (rs == REG_RA) && !ras_empty;

  ras_stack #(.DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (ras_clear),
    .wdata (PcPlus4D + 32'd4),
    .top   (ras_top),
    .empty (ras_empty),
    .full  ()
  );

endmodule

// File: tb/tb_jump_ras_control.sv
// Bench for jump_ras_control: vector table, corner-case sequences, randomized run against a queue model.
module tb_jump_ras_control;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrD, PcPlus4D, rd1D;
  logic        rd1_readyD, validD, stallD, flushD, ras_clear;
  logic        jump1D, ras_predD, jr_stallD;
  logic [31:0] pc_jump1D;
  logic        nr_jump1D, nr_ras_predD, nr_jr_stallD;
  logic [31:0] nr_pc_jump1D;

  always #5 clk = ~clk;

  jump_ras_control #(.DEPTH(DEPTH), .USE_RAS(1)) dut (
    .clk(clk), .rst(rst), .instrD(instrD), .PcPlus4D(PcPlus4D), .rd1D(rd1D),
    .rd1_readyD(rd1_readyD), .validD(validD), .stallD(stallD), .flushD(flushD),
    .ras_clear(ras_clear), .jump1D(jump1D), .pc_jump1D(pc_jump1D),
    .ras_predD(ras_predD), .jr_stallD(jr_stallD)
  );

  jump_ras_control #(.DEPTH(DEPTH), .USE_RAS(0)) dut_noras (
    .clk(clk), .rst(rst), .instrD(instrD), .PcPlus4D(PcPlus4D), .rd1D(rd1D),
    .rd1_readyD(rd1_readyD), .validD(validD), .stallD(stallD), .flushD(flushD),
    .ras_clear(ras_clear), .jump1D(nr_jump1D), .pc_jump1D(nr_pc_jump1D),
    .ras_predD(nr_ras_predD), .jr_stallD(nr_jr_stallD)
  );

  typedef struct {
    logic [31:0] instr, pc4, rd1;
    logic        rdy, valid, stall, flush, clr, rst;
    logic        ej;
    logic [31:0] epc;
    logic        ep, es;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] q[$];

  localparam logic [31:0] JAL_I = 32'h0C10_0010;
  localparam logic [31:0] JAL_T = 32'h0040_0040;

  function automatic logic [31:0] enc_jr(input logic [4:0] rs);
    return {6'd0, rs, 15'd0, 6'b001000};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rs, input logic [4:0] rd);
    return {6'd0, rs, 5'd0, rd, 5'd0, 6'b001001};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc4,
                              input logic [31:0] rd1, input logic rdy, input logic ej,
                              input logic [31:0] epc, input logic ep, input logic es);
    vec_t v;
    v.instr = instr; v.pc4 = pc4; v.rd1 = rd1; v.rdy = rdy;
    v.valid = 1'b1; v.stall = 1'b0; v.flush = 1'b0; v.clr = 1'b0; v.rst = 1'b0;
    v.ej = ej; v.epc = epc; v.ep = ep; v.es = es;
    return v;
  endfunction

  function automatic bit is_abs(input logic [31:0] i);
    return i[31:26] == 6'd2 || i[31:26] == 6'd3;
  endfunction

  function automatic bit is_regj(input logic [31:0] i);
    return i[31:26] == 6'd0 && (i[5:0] == 6'd8 || i[5:0] == 6'd9);
  endfunction

  // Expected outputs from the architectural rules and the current model stack.
  function automatic vec_t with_model(input vec_t v);
    vec_t r;
    r = v;
    r.ej  = v.valid && (is_abs(v.instr) || is_regj(v.instr));
    r.epc = is_abs(v.instr) ? {v.pc4[31:28], v.instr[25:0], 2'b00} : v.rd1;
    r.ep  = 1'b0;
    r.es  = 1'b0;
    if (v.valid && is_regj(v.instr) && !v.rdy) begin
      if (v.instr[25:21] == 5'd31 && q.size() > 0 && !v.rst) begin
        r.ep  = 1'b1;
        r.epc = q[q.size()-1];
      end else begin
        r.es = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_update(input vec_t v);
    vec_t m;
    bit ret, call;
    m = with_model(v);
    ret  = is_regj(v.instr) && v.instr[25:21] == 5'd31;
    call = v.instr[31:26] == 6'd3 ||
           (v.instr[31:26] == 6'd0 && v.instr[5:0] == 6'd9 && v.instr[15:11] == 5'd31);
    if (v.rst || v.clr) begin
      q.delete();
    end else if (v.valid && !v.stall && !v.flush && !m.es) begin
      if (ret && call && q.size() > 0) begin
        q[q.size()-1] = v.pc4 + 32'd4;
      end else begin
        if (ret && q.size() > 0) void'(q.pop_back());
        if (call) begin
          q.push_back(v.pc4 + 32'd4);
          if (q.size() > DEPTH) void'(q.pop_front());
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    instrD = v.instr; PcPlus4D = v.pc4; rd1D = v.rd1; rd1_readyD = v.rdy;
    validD = v.valid; stallD = v.stall; flushD = v.flush; ras_clear = v.clr; rst = v.rst;
    @(negedge clk);
    chk({nm, ".jump"}, 32'(jump1D), 32'(v.ej));
    if (v.ej) chk({nm, ".pc"}, pc_jump1D, v.epc);
    chk({nm, ".pred"}, 32'(ras_predD), 32'(v.ep));
    chk({nm, ".stall"}, 32'(jr_stallD), 32'(v.es));
    chk({nm, ".noras_pred"}, 32'(nr_ras_predD), 32'd0);
    chk({nm, ".noras_stall"}, 32'(nr_jr_stallD),
        32'(v.valid && is_regj(v.instr) && !v.rdy));
    model_update(v);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[15];
  vec_t v;

  initial begin
    rst = 1'b1; instrD = '0; PcPlus4D = '0; rd1D = '0; rd1_readyD = 1'b0;
    validD = 1'b0; stallD = 1'b0; flushD = 1'b0; ras_clear = 1'b0;
    @(posedge clk);
    #1;

    tbl[0]  = mk(32'h0810_0000, 32'h9000_0004, 32'h0, 1'b0, 1'b1, 32'h9040_0000, 1'b0, 1'b0);
    tbl[0].rst = 1'b1;
    tbl[1]  = mk(enc_jr(31), 32'h0, 32'hDEAD_0000, 1'b0, 1'b1, 32'hDEAD_0000, 1'b0, 1'b1);
    tbl[2]  = mk(JAL_I, 32'h0040_0004, 32'h0, 1'b0, 1'b1, JAL_T, 1'b0, 1'b0);
    tbl[3]  = mk(enc_jr(31), 32'h0, 32'h1234_5678, 1'b0, 1'b1, 32'h0040_0008, 1'b1, 1'b0);
    tbl[4]  = mk(enc_jr(31), 32'h0, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b1);
    tbl[5]  = mk(JAL_I, 32'h0040_0004, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tbl[5].valid = 1'b0;
    tbl[6]  = mk(32'h0085_1021, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tbl[7]  = mk(enc_jr(5), 32'h0, 32'hAAAA_0000, 1'b1, 1'b1, 32'hAAAA_0000, 1'b0, 1'b0);
    tbl[8]  = mk(enc_jr(5), 32'h0, 32'hBBBB_0000, 1'b0, 1'b1, 32'hBBBB_0000, 1'b0, 1'b1);
    tbl[9]  = mk(JAL_I, 32'h0000_1000, 32'h0, 1'b0, 1'b1, JAL_T, 1'b0, 1'b0);
    tbl[9].flush = 1'b1;
    tbl[10] = mk(enc_jr(31), 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    tbl[11] = mk(enc_jalr(9, 31), 32'h0000_3004, 32'h0000_7000, 1'b1, 1'b1, 32'h0000_7000, 1'b0, 1'b0);
    tbl[12] = mk(enc_jr(31), 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_3008, 1'b1, 1'b0);
    tbl[13] = mk(enc_jr(31), 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    tbl[13].stall = 1'b1;
    tbl[14] = mk(enc_jr(31), 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tbl[14].valid = 1'b0;
    for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("tbl%0d", i));

    // jalr $31,$31: predicts old top, replaces it in place
    step(mk(JAL_I, 32'h0000_0FFC, 32'h0, 1'b0, 1'b1, JAL_T, 1'b0, 1'b0), "popush.jal");
    step(mk(enc_jalr(31, 31), 32'h0000_2004, 32'h55, 1'b0, 1'b1, 32'h0000_1000, 1'b1, 1'b0), "popush.jalr");
    step(mk(enc_jr(31), 32'h0, 32'h66, 1'b0, 1'b1, 32'h0000_2008, 1'b1, 1'b0), "popush.ret");
    step(mk(enc_jr(31), 32'h0, 32'h66, 1'b0, 1'b1, 32'h66, 1'b0, 1'b1), "popush.empty");

    // overflow: nine calls into an eight-deep stack
    for (int k = 1; k <= 9; k++)
      step(mk(JAL_I, 32'(k * 32'h100 - 4), 32'h0, 1'b0, 1'b1, JAL_T, 1'b0, 1'b0),
           $sformatf("ovf.call%0d", k));
    for (int k = 0; k < 9; k++) begin
      if (k < 8)
        v = mk(enc_jr(31), 32'h0, 32'hBAD, 1'b0, 1'b1, 32'((9 - k) * 32'h100), 1'b1, 1'b0);
      else
        v = mk(enc_jr(31), 32'h0, 32'hBAD, 1'b0, 1'b1, 32'hBAD, 1'b0, 1'b1);
      step(v, $sformatf("ovf.ret%0d", k));
    end

    // stalled call pushes exactly once
    for (int k = 0; k < 4; k++) begin
      v = mk(JAL_I, 32'h0000_04FC, 32'h0, 1'b0, 1'b1, JAL_T, 1'b0, 1'b0);
      v.stall = (k < 3);
      step(v, $sformatf("stl.jal%0d", k));
    end
    step(mk(enc_jr(31), 32'h0, 32'h77, 1'b0, 1'b1, 32'h0000_0500, 1'b1, 1'b0), "stl.ret");
    step(mk(enc_jr(31), 32'h0, 32'h77, 1'b0, 1'b1, 32'h77, 1'b0, 1'b1), "stl.empty");

    // clear wins over a simultaneous call
    for (int k = 1; k <= 3; k++)
      step(mk(JAL_I, 32'(k * 32'h10), 32'h0, 1'b0, 1'b1, JAL_T, 1'b0, 1'b0), $sformatf("clr.call%0d", k));
    v = mk(JAL_I, 32'h40, 32'h0, 1'b0, 1'b1, JAL_T, 1'b0, 1'b0);
    v.clr = 1'b1;
    step(v, "clr.jal");
    step(mk(enc_jr(31), 32'h0, 32'h88, 1'b0, 1'b1, 32'h88, 1'b0, 1'b1), "clr.ret");

    // a resolved jr $31 still pops
    step(mk(JAL_I, 32'h60, 32'h0, 1'b0, 1'b1, JAL_T, 1'b0, 1'b0), "rdy.call");
    step(mk(enc_jr(31), 32'h0, 32'h64, 1'b1, 1'b1, 32'h64, 1'b0, 1'b0), "rdy.ret");
    step(mk(enc_jr(31), 32'h0, 32'h99, 1'b0, 1'b1, 32'h99, 1'b0, 1'b1), "rdy.empty");

    // reset mid-sequence empties the stack
    step(mk(JAL_I, 32'h70, 32'h0, 1'b0, 1'b1, JAL_T, 1'b0, 1'b0), "rst.call1");
    step(mk(JAL_I, 32'h80, 32'h0, 1'b0, 1'b1, JAL_T, 1'b0, 1'b0), "rst.call2");
    v = mk(enc_jr(31), 32'h0, 32'hAB, 1'b0, 1'b1, 32'hAB, 1'b0, 1'b1);
    v.rst = 1'b1;
    step(v, "rst.during");
    step(mk(enc_jr(31), 32'h0, 32'hAC, 1'b0, 1'b1, 32'hAC, 1'b0, 1'b1), "rst.after");

    for (int n = 0; n < 800; n++) begin
      int pick;
      pick = $urandom_range(0, 9);
      case (pick)
        0, 8, 9: v.instr = {6'd3, 26'($urandom)};
        1:       v.instr = {6'd2, 26'($urandom)};
        2:       v.instr = enc_jr(31);
        3:       v.instr = enc_jr(5'($urandom_range(0, 31)));
        4:       v.instr = enc_jalr(31, 31);
        5:       v.instr = enc_jalr(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        6:       v.instr = $urandom;
        default: v.instr = enc_jalr(31, 5'($urandom_range(0, 31)));
      endcase
      v.pc4   = $urandom;
      v.rd1   = $urandom;
      v.rdy   = ($urandom_range(0, 9) < 3);
      v.valid = ($urandom_range(0, 9) != 0);
      v.stall = ($urandom_range(0, 6) == 0);
      v.flush = ($urandom_range(0, 9) == 0);
      v.clr   = ($urandom_range(0, 39) == 0);
      v.rst   = ($urandom_range(0, 79) == 0);
      v = with_model(v);
      step(v, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
